// File: rtl/axis_s_to_dac_parallel_pkg.sv
// axis_s_to_dac_parallel_pkg: shared state encoding, DAC midscale codes and status field positions
package axis_s_to_dac_parallel_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} dac_state_e;
  localparam logic [13:0] MIDSCALE_OB = 14'h2000;
  localparam logic [13:0] MIDSCALE_TC = 14'h0000;
  localparam int ENTRY_W = 17;
  localparam int ST_UCNT_LSB = 0;
  localparam int ST_LEVEL_LSB = 16;
  localparam int ST_RUN_BIT = 24;
  localparam int ST_STICKY_BIT = 25;
  localparam int ST_TLAST_LSB = 26;
endpackage

// File: rtl/axis_dac_fifo.sv
// axis_dac_fifo: show-ahead synchronous FIFO holding {tlast, sample} entries
module axis_dac_fifo
  import axis_s_to_dac_parallel_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W = ENTRY_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign level = cnt_q;
  assign dout = mem_q[rd_q];
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  // storage array is written only on accepted pushes and needs no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/axis_s_to_dac_parallel.sv
// axis_s_to_dac_parallel: AXI4-Stream sample sink driving a parallel DAC with its divided sample clock
module axis_s_to_dac_parallel
  import axis_s_to_dac_parallel_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int DAC_WIDTH = 14,
  parameter int CLK_DIV = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  output logic                                ClockToDAC,
  output logic [DAC_WIDTH-1:0]                DACdata,
  input  logic [3:0]                          control,
  output logic [31:0]                         status
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic clk_q, rdy_q, upd;
  dac_state_e state_q, state_d;
  logic [DAC_WIDTH-1:0] dac_q, dac_d, mid, s, conv;
  logic [15:0] ucnt_q, ucnt_d;
  logic sticky_q, sticky_d;
  logic [5:0] tl_q, tl_d;
  logic en, flush, tc, hold;
  logic push, pop, full, empty, primed;
  logic [ENTRY_W-1:0] head;
  logic [LW-1:0] level;
  logic unused_ok;
  assign unused_ok = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16]};
  assign en = control[0];
  assign flush = control[1];
  assign tc = control[2];
  assign hold = control[3];
  assign cnt_d = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
  assign upd = cnt_q == CW'(HALF - 1);
  assign s00_axis_tready = rdy_q && !full && !flush;
  assign push = s00_axis_tvalid && s00_axis_tready;
  assign primed = level >= LW'(PRIME_LEVEL);
  assign mid = tc ? MIDSCALE_TC : MIDSCALE_OB;
  assign s = head[15 -: DAC_WIDTH];
  assign conv = tc ? s : {~s[DAC_WIDTH-1], s[DAC_WIDTH-2:0]};
  assign ClockToDAC = clk_q;
  assign DACdata = dac_q;
  axis_dac_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk   (s00_axis_aclk),
    .rst_n (s00_axis_aresetn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({s00_axis_tlast, s00_axis_tdata[15:0]}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );
  // divider, registered DAC clock (registered so it reads 0 in reset), FSM and counters
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
      rdy_q <= 1'b0;
      state_q <= ST_IDLE;
      dac_q <= MIDSCALE_OB;
      ucnt_q <= '0;
      sticky_q <= 1'b0;
      tl_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= cnt_d < CW'(HALF);
      rdy_q <= 1'b1;
      state_q <= state_d;
      dac_q <= dac_d;
      ucnt_q <= ucnt_d;
      sticky_q <= sticky_d;
      tl_q <= tl_d;
    end
  end
  // next state: DAC output and pops happen only on the update edge (DAC clock falling)
  always_comb begin
    state_d = state_q;
    dac_d = dac_q;
    pop = 1'b0;
    ucnt_d = ucnt_q;
    sticky_d = sticky_q;
    tl_d = tl_q;
    if (flush) begin
      state_d = ST_IDLE;
      ucnt_d = '0;
      sticky_d = 1'b0;
      tl_d = '0;
      dac_d = upd ? mid : dac_q;
    end else if (upd && !en) begin
      state_d = ST_IDLE;
      dac_d = mid;
    end else if (upd) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_PRIME;
        dac_d = mid;
      end else if (state_q == ST_PRIME && !primed) begin
        dac_d = mid;
      end else if (!empty) begin
        pop = 1'b1;
        state_d = ST_RUN;
        dac_d = conv;
        tl_d = tl_q + {5'b0, head[16]};
      end else begin
        dac_d = hold ? dac_q : mid;
        ucnt_d = (ucnt_q == 16'hFFFF) ? ucnt_q : ucnt_q + 1'b1;
        sticky_d = 1'b1;
      end
    end else if (state_q == ST_IDLE && en) begin
      state_d = ST_PRIME;
    end
  end
  // status word assembled from live registers
  always_comb begin
    status = '0;
    status[ST_UCNT_LSB +: 16] = ucnt_q;
    status[ST_LEVEL_LSB +: LW] = level;
    status[ST_RUN_BIT] = state_q == ST_RUN;
    status[ST_STICKY_BIT] = sticky_q;
    status[ST_TLAST_LSB +: 6] = tl_q;
  end
endmodule

// File: tb/tb_axis_s_to_dac_parallel.sv
// tb_axis_s_to_dac_parallel: directed and random stimulus against a queue-based reference model
module tb_axis_s_to_dac_parallel;
  localparam int CLK_DIV = 4;
  localparam int DEPTH = 16;
  localparam int PRIME = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tvalid = 1'b0;
  logic [31:0] tdata = '0;
  logic [3:0] tstrb = '0;
  logic tlast = 1'b0;
  logic tready, dclk;
  logic [13:0] dac;
  logic [3:0] control = '0;
  logic [31:0] status;
  int checks = 0;
  int failures = 0;
  logic [16:0] q[$];
  int ph, mode, ucnt, tl;
  bit mclk, mrdy, sticky;
  logic [13:0] mdac, prev_dac;
  bit prev_clk;
  axis_s_to_dac_parallel dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (tvalid),
    .s00_axis_tdata   (tdata),
    .s00_axis_tstrb   (tstrb),
    .s00_axis_tlast   (tlast),
    .s00_axis_tready  (tready),
    .ClockToDAC       (dclk),
    .DACdata          (dac),
    .control          (control),
    .status           (status)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [13:0] mid(input bit tc);
    return tc ? 14'h0000 : 14'h2000;
  endfunction
  function automatic logic [13:0] conv(input logic [16:0] e, input bit tc);
    logic [13:0] v;
    v = e[15:2];
    return tc ? v : v ^ 14'h2000;
  endfunction
  function automatic bit m_tready();
    return rst_n && mrdy && q.size() < DEPTH && !control[1];
  endfunction
  function automatic logic [31:0] m_status();
    return {6'(tl), sticky, mode == 2, 3'b000, 5'(q.size()), 16'(ucnt)};
  endfunction
  task automatic model_reset();
    q.delete();
    ph = 0; mode = 0; ucnt = 0; tl = 0;
    mclk = 0; mrdy = 0; sticky = 0;
    mdac = 14'h2000; prev_dac = 14'h2000; prev_clk = 0;
  endtask
  task automatic model_step();
    bit upd, push;
    logic [16:0] e, h;
    if (!rst_n) return;
    upd = ph == CLK_DIV / 2 - 1;
    push = tvalid && m_tready();
    e = {tlast, tdata[15:0]};
    if (control[1]) begin
      q.delete(); mode = 0; ucnt = 0; sticky = 0; tl = 0;
      if (upd) mdac = mid(control[2]);
    end else if (upd && !control[0]) begin
      mode = 0; mdac = mid(control[2]);
    end else if (upd) begin
      if (mode == 0) begin
        mode = 1; mdac = mid(control[2]);
      end else if (mode == 1 && q.size() < PRIME) begin
        mdac = mid(control[2]);
      end else if (q.size() > 0) begin
        h = q.pop_front();
        mode = 2; mdac = conv(h, control[2]); tl = (tl + int'(h[16])) % 64;
      end else begin
        if (!control[3]) mdac = mid(control[2]);
        if (ucnt < 65535) ucnt++;
        sticky = 1;
      end
    end else if (mode == 0 && control[0]) begin
      mode = 1;
    end
    if (push) q.push_back(e);
    ph = (ph + 1) % CLK_DIV;
    mclk = ph < CLK_DIV / 2;
    mrdy = 1;
  endtask
  task automatic check_all();
    chk("tready", tready, m_tready());
    chk("dac_clk", dclk, mclk);
    chk("dac_data", dac, mdac);
    chk("status", status, m_status());
    if (dac !== prev_dac) chk("dac_edge", {prev_clk, dclk}, 2'b10);
    prev_dac = dac;
    prev_clk = dclk;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wait_run(input string tag);
    int n = 0;
    while (status[24] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, status[24], 1'b1);
  endtask
  initial begin
    logic [31:0] r;
    int k;
    model_reset();
    tvalid = 1'b1;
    run(3);
    chk("rst_tready", tready, 1'b0);
    chk("rst_clk", dclk, 1'b0);
    chk("rst_dac", dac, 14'h2000);
    chk("rst_status", status, 32'h0);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      tdata = {$urandom_range(0, 65535), 16'(k * 4)};
      tstrb = 4'($urandom);
      if (tready) k++;
      tick();
    end
    chk("fill_tready", tready, 1'b0);
    chk("fill_level", status[20:16], 5'd16);
    chk("fill_dac", dac, 14'h2000);
    control = 4'b0001;
    for (int i = 0; i < 200 && status[24] !== 1'b1; i++) begin
      tdata = {16'h0, 16'(k * 4)};
      if (tready) k++;
      tick();
    end
    chk("ramp_run", status[24], 1'b1);
    chk("ramp_first", dac, 14'h2000);
    for (int i = 0; i < CLK_DIV; i++) begin
      tdata = {16'h0, 16'(k * 4)};
      if (tready) k++;
      tick();
    end
    chk("ramp_second", dac, 14'h2001);
    for (int i = 0; i < 60; i++) begin
      tdata = {16'h0, 16'(k * 4)};
      if (tready) k++;
      tick();
    end
    tvalid = 1'b0;
    run(120);
    chk("urun_mid", dac, 14'h2000);
    chk("urun_sticky", status[25], 1'b1);
    control = 4'b0010;
    run(3);
    chk("flush_status", status, 32'h0);
    control = 4'b1101;
    tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tdata = (i == 0) ? 32'h8000 : (i == 1) ? 32'h7FFC : (i == 7) ? 32'h1234 : $urandom;
      tick();
    end
    tvalid = 1'b0;
    wait_run("tc_run");
    chk("tc_first", dac, 14'h2000);
    run(CLK_DIV);
    chk("tc_second", dac, 14'h1FFF);
    run(80);
    chk("hold_last", dac, 14'h048D);
    chk("hold_sticky", status[25], 1'b1);
    control = 4'b0010;
    run(2);
    control = 4'b0000;
    tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tdata = $urandom;
      tlast = (i == 7) || (i == 15);
      tick();
    end
    tvalid = 1'b0;
    tlast = 1'b0;
    run(10);
    control = 4'b0001;
    run(100);
    chk("tlast_count", status[31:26], 6'd2);
    control = 4'b0011;
    run(2);
    chk("flush_run", status, 32'h0);
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) begin
        r = $urandom;
        control = {r[3:2], $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0};
      end else control[1] = 1'b0;
      tvalid = $urandom_range(0, 99) < (((i / 200) % 2) ? 15 : 60);
      tdata = $urandom;
      tstrb = 4'($urandom);
      tlast = $urandom_range(0, 5) == 0;
      tick();
    end
    control = 4'b0001;
    tvalid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tdata = $urandom;
      tick();
    end
    chk("pre_rst_level", status[20:16], 5'd16);
    chk("pre_rst_run", status[24], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_tready", tready, 1'b0);
    chk("mid_rst_clk", dclk, 1'b0);
    chk("mid_rst_dac", dac, 14'h2000);
    chk("mid_rst_status", status, 32'h0);
    model_reset();
    @(negedge clk);
    run(3);
    rst_n = 1'b1;
    tvalid = 1'b0;
    run(20);
    for (int i = 0; i < PRIME - 1; i++) begin
      tvalid = 1'b1;
      tdata = $urandom;
      tick();
    end
    tvalid = 1'b0;
    run(40);
    chk("prime_wait", status[24], 1'b0);
    tvalid = 1'b1;
    tdata = $urandom;
    tick();
    tvalid = 1'b0;
    wait_run("prime_run");
    run(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
